// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-draining 8N1 UART transmitter.
//   tx_state_e : transmitter FSM states
//   DATA_W     : payload bits per frame
//   FRAME_BITS : line bits per frame (start + data + stop)
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, marking the last cycle of
// each serial bit period.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : hold counter at 0 (released on the first cycle of a start bit)
//   bit_end : high on the last cycle of every bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = !clr && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains bytes from a FIFO and sends each as an 8N1 serial frame
// (start 0, 8 data bits LSB first, stop 1).
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   fifo_dout  : FIFO read data, valid the cycle after fifo_rd
//   fifo_empty : FIFO empty flag, only looked at in IDLE
//   fifo_rd    : registered one-cycle read strobe
//   tx_en      : gate for starting new frames; a running frame always finishes
//   tx         : serial line, idles high
//   busy       : high from READ through the last STOP cycle
//   frame_done : one-cycle pulse in the IDLE cycle following STOP
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic              tx_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  // Index of the final data bit within the frame's data field.
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timer_clr;
  logic              bit_end;

  // The counter is held at 0 until the line leaves idle, so the first START
  // cycle always sees count 0.
  assign timer_clr = (state_q == S_IDLE) || (state_q == S_READ) ||
                     (state_q == S_LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE:  if (tx_en && !fifo_empty) state_d = S_READ;
      S_READ:  state_d = S_LOAD;
      S_LOAD: begin
        shift_d   = fifo_dout;
        bit_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they move with the state.
    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
    rd_d   = (state_d == S_READ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd    = rd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Scoreboard bench: stimulus loads a FIFO model and queues the bytes that must
// appear on the line; a monitor decodes every frame on tx and compares it to
// the queue head, alongside checks on fifo_rd, busy and frame_done timing.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       tx_en = 1'b0;
  logic       tx;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .tx_en     (tx_en),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // FIFO model: registered read data, empty when pointers meet.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit on_line);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
    if (on_line) exp_q.push_back(b);
  endtask

  // ---------------- monitor ----------------
  bit         in_frame = 0;
  bit         have_exp = 0;
  bit         expect_done = 0;
  logic       rd_prev_lvl = 1'b0;
  logic       lvl;
  logic [7:0] cur_exp = 8'h00;
  logic [7:0] rx = 8'h00;
  int pos = 0, bit_k = 0, bit_err = 0;
  int stray_done = 0, rd_count = 0, rd_last = 0, rd_prev = 0, rd_viol = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (fifo_rd === 1'b1) begin
        if (fifo_empty || rd_prev_lvl) rd_viol++;
        rd_count++;
        rd_prev = rd_last;
        rd_last = cyc;
      end
      rd_prev_lvl = fifo_rd;

      if (expect_done) begin
        chk("frame_done_pulse", int'(frame_done), 1);
        expect_done = 0;
      end else if (frame_done === 1'b1) begin
        stray_done++;
      end

      if (rst) begin
        in_frame = 0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1;
          pos      = 0;
          bit_err  = 0;
          rx       = 8'h00;
          chk("start_after_rd", cyc - rd_last, 2);
          have_exp = (exp_q.size() > 0);
          chk("frame_expected", int'(have_exp), 1);
          cur_exp = have_exp ? exp_q[0] : 8'h00;
        end
        if (in_frame) begin
          bit_k = pos / CPB;
          if (bit_k == 0)      lvl = 1'b0;
          else if (bit_k == 9) lvl = 1'b1;
          else                 lvl = cur_exp[bit_k-1];
          if (tx !== lvl) bit_err++;
          if (busy !== 1'b1) bit_err++;
          if (bit_k >= 1 && bit_k <= 8 && (pos % CPB) == CPB / 2) rx[bit_k-1] = tx;
          pos++;
          if (pos == 10 * CPB) begin
            chk("frame_line", bit_err, 0);
            chk("frame_byte", int'(rx), int'(cur_exp));
            if (have_exp) void'(exp_q.pop_front());
            in_frame    = 0;
            expect_done = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input string nm, input int maxc);
    int seen = 0;
    for (int i = 0; i < maxc && seen == 0; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1;
    end
    chk(nm, seen, 1);
  endtask

  task automatic wait_tx_low(input string nm, input int maxc);
    int seen = 0;
    for (int i = 0; i < maxc && seen == 0; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    int rel, r0, lowc, busyc;

    // Reset held with a non-empty FIFO.
    rst   = 1'b1;
    tx_en = 1'b1;
    push_byte(8'hA5, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_fifo_rd", int'(fifo_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_no_reads", rd_count, 0);

    // Single byte 0xA5.
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    wait_done("t1_done", 200);
    chk("t1_rd_count", rd_count, 1);
    chk("t1_rd_latency", rd_last - rel, 1);

    // Back-to-back 0x00, 0xFF.
    @(posedge clk);
    #1;
    r0 = rd_count;
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    wait_done("t2_done_a", 200);
    wait_done("t2_done_b", 200);
    chk("t2_rd_count", rd_count - r0, 2);
    chk("t2_rd_gap", rd_last - rd_prev, 43);

    // Empty FIFO for 100 cycles.
    r0 = rd_count;
    lowc = 0;
    busyc = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lowc++;
      if (busy !== 1'b0) busyc++;
    end
    chk("empty_rd", rd_count - r0, 0);
    chk("empty_tx_low_cycles", lowc, 0);
    chk("empty_busy_cycles", busyc, 0);

    // tx_en dropped during DATA of 0x3C with 0x81 queued.
    @(posedge clk);
    #1;
    r0 = rd_count;
    push_byte(8'h3C, 1'b1);
    push_byte(8'h81, 1'b1);
    wait_tx_low("t4_start", 50);
    repeat (3 * CPB) @(posedge clk);
    #1 tx_en = 1'b0;
    wait_done("t4_done_first", 200);
    repeat (40) @(negedge clk);
    chk("t4_no_second_rd", rd_count - r0, 1);
    chk("t4_parked_busy", int'(busy), 0);
    chk("t4_parked_tx", int'(tx), 1);
    @(posedge clk);
    #1 tx_en = 1'b1;
    wait_done("t4_done_second", 200);
    chk("t4_rd_total", rd_count - r0, 2);

    // Reset in the middle of data bit 4; 0x5A is lost, 0x96 follows.
    @(posedge clk);
    #1;
    r0 = rd_count;
    push_byte(8'h5A, 1'b0);
    push_byte(8'h96, 1'b1);
    wait_tx_low("t5_start", 50);
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_tx", int'(tx), 1);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_frame_done", int'(frame_done), 0);
    wait_done("t5_resend_done", 200);
    chk("t5_rd_total", rd_count - r0, 2);

    repeat (10) @(negedge clk);
    chk("all_frames_seen", exp_q.size(), 0);
    chk("stray_frame_done", stray_done, 0);
    chk("fifo_rd_violations", rd_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got 20000 cycles without completion, expected bench to finish");
    $fatal(1, "watchdog timeout");
  end

endmodule
